// File: rtl/reg_32b_if.sv
// Register-file access bus: shared address, write data, active-low write enable, read data.
// The master drives address/data/enable; the slave (register file) drives read data.
interface reg_32b_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] d_in;
  logic              we_;
  logic [DATA_W-1:0] d_out;

  modport master (output addr, output d_in, output we_, input d_out);
  modport slave  (input addr, input d_in, input we_, output d_out);
endinterface

// File: rtl/reg_32b.sv
// General-purpose register file: one synchronous write port, one combinational read port.
// Optional macro REG_ZERO_WIRED_EN makes word 0 a hardwired zero (RISC-style r0).
module reg_32b #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_D = 32
) (
  input logic     clk,
  input logic     reset_,
  reg_32b_if.slave bus
);

`ifdef REG_ZERO_WIRED_EN
  localparam int unsigned FirstWord = 1;
`else
  localparam int unsigned FirstWord = 0;
`endif

  logic [DATA_W-1:0] ff_q [DATA_D];
  logic [DATA_W-1:0] ff_d [DATA_D];

  // Only in-range addresses ever match, so out-of-range writes fall through untouched.
  always_comb begin
    ff_d = ff_q;
    if (!bus.we_) begin
      for (int unsigned i = FirstWord; i < DATA_D; i++) begin
        if (bus.addr == ADDR_W'(i)) begin
          ff_d[i] = bus.d_in;
        end
      end
    end
  end

  // Out-of-range (and wired-zero) addresses leave the default of zero on the read port.
  always_comb begin
    bus.d_out = '0;
    for (int unsigned i = FirstWord; i < DATA_D; i++) begin
      if (bus.addr == ADDR_W'(i)) begin
        bus.d_out = ff_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      ff_q <= '{default: '0};
    end else begin
      ff_q <= ff_d;
    end
  end

endmodule

// File: tb/tb_reg_32b.sv
// Scoreboard bench for reg_32b: a full-depth instance and a 20-word instance share stimulus;
// expected reads come from an array model and are checked by a separate monitor at negedge.
module tb_reg_32b;
  localparam int unsigned DW     = 32;
  localparam int unsigned AW     = 5;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned DEPTHS = 20;

  logic          clk;
  logic          reset_;
  logic [AW-1:0] addr;
  logic [DW-1:0] d_in;
  logic          we_;
  logic          chk_stb;

  reg_32b_if #(.DATA_W(DW), .ADDR_W(AW)) bus   ();
  reg_32b_if #(.DATA_W(DW), .ADDR_W(AW)) bus_s ();

  assign bus.addr   = addr;
  assign bus.d_in   = d_in;
  assign bus.we_    = we_;
  assign bus_s.addr = addr;
  assign bus_s.d_in = d_in;
  assign bus_s.we_  = we_;

  reg_32b #(.DATA_W(DW), .ADDR_W(AW), .DATA_D(DEPTH)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus)
  );

  reg_32b #(.DATA_W(DW), .ADDR_W(AW), .DATA_D(DEPTHS)) dut_s (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: plain word arrays.
  logic [DW-1:0] mem   [DEPTH];
  logic [DW-1:0] mem_s [DEPTHS];

  logic [DW-1:0] exp_q   [$];
  logic [DW-1:0] exp_s_q [$];
  string         name_q  [$];

  int checks = 0;
  int errors = 0;

  function automatic logic [DW-1:0] model_rd(int unsigned a, int unsigned depth, logic [DW-1:0] w);
`ifdef REG_ZERO_WIRED_EN
    if (a == 0) return '0;
`endif
    if (a >= depth) return '0;
    return w;
  endfunction

  function automatic bit model_wr_ok(int unsigned a, int unsigned depth);
`ifdef REG_ZERO_WIRED_EN
    if (a == 0) return 1'b0;
`endif
    return a < depth;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    for (int i = 0; i < DEPTHS; i++) mem_s[i] = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk_stb = 1'b0;
    we_     = 1'b1;
  endtask

  // Issue a write; it lands on the next rising edge.
  task automatic wr(input int unsigned a, input logic [DW-1:0] d);
    step();
    addr = AW'(a);
    d_in = d;
    we_  = 1'b0;
    if (model_wr_ok(a, DEPTH)) mem[a] = d;
    if (model_wr_ok(a, DEPTHS)) mem_s[a] = d;
  endtask

  // Request a read check in the current cycle, no clock edge in between.
  task automatic rd_now(input int unsigned a, input string n);
    logic [DW-1:0] ws;
    ws   = (a < DEPTHS) ? mem_s[a] : '0;
    addr = AW'(a);
    exp_q.push_back(model_rd(a, DEPTH, mem[a]));
    exp_s_q.push_back(model_rd(a, DEPTHS, ws));
    name_q.push_back(n);
    chk_stb = 1'b1;
  endtask

  task automatic rd(input int unsigned a, input string n);
    step();
    rd_now(a, n);
  endtask

  logic [DW-1:0] mon_e;
  logic [DW-1:0] mon_es;
  string         mon_n;

  always @(negedge clk) begin
    if (chk_stb) begin
      if (exp_q.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL scoreboard_empty: read presented with no expected value queued");
      end else begin
        mon_e  = exp_q.pop_front();
        mon_es = exp_s_q.pop_front();
        mon_n  = name_q.pop_front();
        checks = checks + 1;
        if (bus.d_out !== mon_e) begin
          errors = errors + 1;
          $display("FAIL %s addr=%0d: got %h, expected %h", mon_n, addr, bus.d_out, mon_e);
        end
        checks = checks + 1;
        if (bus_s.d_out !== mon_es) begin
          errors = errors + 1;
          $display("FAIL %s_d20 addr=%0d: got %h, expected %h", mon_n, addr, bus_s.d_out, mon_es);
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] r;
    int unsigned   a;
    reset_  = 1'b0;
    addr    = '0;
    d_in    = '0;
    we_     = 1'b1;
    chk_stb = 1'b0;
    model_clear();

    // Reset asserted between edges: contents read zero before any edge.
    step();
    reset_ = 1'b1;
    model_clear();
    rd_now(0, "reset_immediate");
    for (int i = 0; i < 32; i++) rd(i, "reset_sweep");
    step();
    reset_ = 1'b0;

    // Write sweep then read back every word.
    for (int i = 0; i < 32; i++) wr(i, DW'(i));
    for (int i = 0; i < 32; i++) rd(i, "write_sweep");

    // Hold with we_ high and noisy d_in.
    wr(5, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      step();
      addr = 5'd5;
      d_in = 32'hFFFFFFFF;
    end
    rd(5, "hold");
    rd(4, "hold_neighbour");

    // No bypass: old value visible until the edge, new one after.
    wr(7, 32'h11);
    step();
    addr = 5'd7;
    d_in = 32'h22;
    we_  = 1'b0;
    rd_now(7, "no_bypass_before");
    if (model_wr_ok(7, DEPTH)) mem[7] = 32'h22;
    if (model_wr_ok(7, DEPTHS)) mem_s[7] = 32'h22;
    rd(7, "no_bypass_after");

    // Between-edge glitch on we_ must not write.
    step();
    addr = 5'd9;
    d_in = 32'hBAD0BAD0;
    we_  = 1'b0;
    #2;
    we_  = 1'b1;
    rd(9, "we_glitch");

    // Reset mid-run clears at once; first edge after release writes normally.
    wr(31, 32'hA5A5A5A5);
    rd(31, "pre_reset");
    step();
    reset_ = 1'b1;
    model_clear();
    rd_now(31, "mid_reset");
    step();
    reset_ = 1'b0;
    rd_now(5, "after_reset");
    wr(31, 32'h0000_0077);
    rd(31, "write_after_release");

    // Reset dominates a simultaneous write request.
    step();
    addr   = 5'd3;
    d_in   = 32'h99;
    we_    = 1'b0;
    reset_ = 1'b1;
    model_clear();
    step();
    reset_ = 1'b0;
    rd_now(3, "reset_dominates");

    // Word 0 / word 1 behaviour (wired-zero when enabled).
    wr(0, 32'h1234);
    rd(0, "word0");
    wr(1, 32'h5678);
    rd(1, "word1");

    // Out-of-range on the 20-word instance is exercised by these writes/reads.
    wr(25, 32'hCAFEF00D);
    rd(25, "high_addr");

    // Randomised mix of writes and reads, including combinational address changes.
    for (int k = 0; k < 300; k++) begin
      a = $urandom_range(31, 0);
      if ($urandom_range(1, 0) == 1) begin
        r = $urandom();
        wr(a, r);
      end else begin
        rd(a, "random_read");
      end
    end
    for (int i = 0; i < 32; i++) rd(i, "final_sweep");

    step();
    step();
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain: %0d expected reads never presented, expected 0",
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
